sparse_mac_pe: RTL and testbench

SPARSE_MAC_PE -- requirements
Module: sparse_mac_pe

---
 rtl/sparse_pkg.sv | 38 +++
 rtl/sparse_mult_lane.sv | 39 +++
 rtl/sparse_mac_pe.sv | 106 ++++++++++
 tb/tb_sparse_mac_pe.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sparse_pkg.sv
// Shared constants and the accumulator saturate/wrap helper for the sparse MAC PE.
package sparse_pkg;

    localparam int N_NZ_DEF       = 2;
    localparam int M_GRP_DEF      = 4;
    localparam int DATA_WIDTH_DEF = 8;
    localparam int ACC_WIDTH_DEF  = 24;

    typedef struct packed {
        logic        ovf;
        logic [63:0] value;
    } sat_res_t;

    // Adds at 64-bit precision; the caller keeps the low width bits, which gives
    // two's-complement wrap when saturation is off.
    function automatic sat_res_t sat_add(
        input logic signed [63:0] a,
        input logic signed [63:0] b,
        input int                 width,
        input logic               sat_en
    );
        logic signed [63:0] sum;
        logic signed [63:0] max_v;
        logic signed [63:0] min_v;
        sat_res_t           r;
        sum   = a + b;
        max_v = (64'sd1 <<< (width - 1)) - 64'sd1;
        min_v = -(64'sd1 <<< (width - 1));
        r.ovf = (sum > max_v) || (sum < min_v);
        if (r.ovf && sat_en) begin
            r.value = (sum > max_v) ? max_v : min_v;
        end else begin
            r.value = sum;
        end
        return r;
    endfunction

endpackage

// File: rtl/sparse_mult_lane.sv
// One compressed-weight lane: index-select an activation, multiply, register the product.
module sparse_mult_lane #(
    parameter int DATA_WIDTH = 8,
    parameter int M_GRP      = 4,
    parameter int IDX_W      = 2
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                en,
    input  logic [M_GRP-1:0][DATA_WIDTH-1:0]    act_vec,
    input  logic [DATA_WIDTH-1:0]               w_val,
    input  logic [IDX_W-1:0]                    w_idx,
    output logic [2*DATA_WIDTH-1:0]             prod
);

    logic [DATA_WIDTH-1:0]          sel_act;
    logic signed [2*DATA_WIDTH-1:0] prod_next;

    // An index with no matching activation leaves sel_act at zero.
    always_comb begin
        sel_act = '0;
        for (int k = 0; k < M_GRP; k++) begin
            if (w_idx == IDX_W'(k)) begin
                sel_act = act_vec[k];
            end
        end
    end

    assign prod_next = $signed(sel_act) * $signed(w_val);

    always_ff @(posedge clk) begin
        if (rst) begin
            prod <= '0;
        end else if (en) begin
            prod <= prod_next;
        end
    end

endmodule

// File: rtl/sparse_mac_pe.sv
// Two-stage sparse MAC: lane products in stage 1, group accumulate and result hand-off in stage 2.
module sparse_mac_pe
    import sparse_pkg::*;
#(
    parameter int N_NZ       = N_NZ_DEF,
    parameter int M_GRP      = M_GRP_DEF,
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int ACC_WIDTH  = ACC_WIDTH_DEF,
    parameter int SAT_EN     = 1,
    localparam int IDX_W     = $clog2(M_GRP)
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                in_valid,
    output logic                                in_ready,
    input  logic                                in_last,
    input  logic [N_NZ-1:0][DATA_WIDTH-1:0]     w_val,
    input  logic [N_NZ-1:0][IDX_W-1:0]          w_idx,
    input  logic [M_GRP-1:0][DATA_WIDTH-1:0]    act_vec,
    output logic                                out_valid,
    input  logic                                out_ready,
    output logic signed [ACC_WIDTH-1:0]         psum_out,
    output logic                                ovf_out
);

    logic                                advance;
    logic [N_NZ-1:0][2*DATA_WIDTH-1:0]   prods;
    logic                                s1_valid_reg;
    logic                                s1_last_reg;
    logic [ACC_WIDTH-1:0]                acc_reg;
    logic                                ovf_grp_reg;
    logic signed [63:0]                  lane_sum;
    logic signed [63:0]                  acc_ext;
    sat_res_t                            res;
    logic                                unused_hi;

    // Every stage moves together; nothing advances while a result is held.
    assign in_ready = !out_valid || out_ready;
    assign advance  = in_ready;

    generate
        for (genvar gi = 0; gi < N_NZ; gi++) begin : g_lane
            sparse_mult_lane #(
                .DATA_WIDTH (DATA_WIDTH),
                .M_GRP      (M_GRP),
                .IDX_W      (IDX_W)
            ) u_lane (
                .clk     (clk),
                .rst     (rst),
                .en      (advance),
                .act_vec (act_vec),
                .w_val   (w_val[gi]),
                .w_idx   (w_idx[gi]),
                .prod    (prods[gi])
            );
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_reg <= 1'b0;
            s1_last_reg  <= 1'b0;
        end else if (advance) begin
            s1_valid_reg <= in_valid;
            s1_last_reg  <= in_last;
        end
    end

    always_comb begin
        lane_sum = '0;
        for (int i = 0; i < N_NZ; i++) begin
            lane_sum = lane_sum +
                {{(64-2*DATA_WIDTH){prods[i][2*DATA_WIDTH-1]}}, prods[i]};
        end
    end

    assign acc_ext   = {{(64-ACC_WIDTH){acc_reg[ACC_WIDTH-1]}}, acc_reg};
    assign res       = sat_add(acc_ext, lane_sum, ACC_WIDTH, SAT_EN != 0);
    assign unused_hi = ^res.value[63:ACC_WIDTH];

    // A last packet publishes acc+sum and restarts the group on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_reg     <= '0;
            ovf_grp_reg <= 1'b0;
            out_valid   <= 1'b0;
            psum_out    <= '0;
            ovf_out     <= 1'b0;
        end else if (advance) begin
            out_valid <= 1'b0;
            if (s1_valid_reg) begin
                if (s1_last_reg) begin
                    psum_out    <= res.value[ACC_WIDTH-1:0];
                    ovf_out     <= ovf_grp_reg | res.ovf;
                    out_valid   <= 1'b1;
                    acc_reg     <= '0;
                    ovf_grp_reg <= 1'b0;
                end else begin
                    acc_reg     <= res.value[ACC_WIDTH-1:0];
                    ovf_grp_reg <= ovf_grp_reg | res.ovf;
                end
            end
        end
    end

endmodule

// File: tb/tb_sparse_mac_pe.sv
// Directed scoreboard bench: four PE variants share stimulus, each checked against a behavioural model.
module tb_sparse_mac_pe;

    typedef struct packed {
        logic [3:0]       o;
        logic [3:0][63:0] p;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            in_valid = 1'b0;
    logic            in_last = 1'b0;
    logic            out_ready = 1'b1;
    logic [1:0][7:0] w_val = '0;
    logic [1:0][1:0] w_idx = '0;
    logic [3:0][7:0] act_vec = '0;
    logic [2:0][7:0] act3 = '0;

    logic               ir_def, ir_sat, ir_wrap, ir_m3;
    logic               ov_def, ov_sat, ov_wrap, ov_m3;
    logic               of_def, of_sat, of_wrap, of_m3;
    logic signed [23:0] ps_def, ps_m3;
    logic signed [7:0]  ps_sat, ps_wrap;

    int     vectors = 0;
    int     miscompares = 0;
    exp_t   sb[$];
    exp_t   e;
    longint macc[4];
    bit     movf[4];

    always #5 clk = ~clk;

    sparse_mac_pe u_def (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir_def), .in_last(in_last),
        .w_val(w_val), .w_idx(w_idx), .act_vec(act_vec), .out_valid(ov_def),
        .out_ready(out_ready), .psum_out(ps_def), .ovf_out(of_def));

    sparse_mac_pe #(.ACC_WIDTH(8), .SAT_EN(1)) u_sat (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir_sat), .in_last(in_last),
        .w_val(w_val), .w_idx(w_idx), .act_vec(act_vec), .out_valid(ov_sat),
        .out_ready(out_ready), .psum_out(ps_sat), .ovf_out(of_sat));

    sparse_mac_pe #(.ACC_WIDTH(8), .SAT_EN(0)) u_wrap (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir_wrap), .in_last(in_last),
        .w_val(w_val), .w_idx(w_idx), .act_vec(act_vec), .out_valid(ov_wrap),
        .out_ready(out_ready), .psum_out(ps_wrap), .ovf_out(of_wrap));

    sparse_mac_pe #(.M_GRP(3)) u_m3 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir_m3), .in_last(in_last),
        .w_val(w_val), .w_idx(w_idx), .act_vec(act3), .out_valid(ov_m3),
        .out_ready(out_ready), .psum_out(ps_m3), .ovf_out(of_m3));

    function automatic int aw(int k);
        return (k == 1 || k == 2) ? 8 : 24;
    endfunction

    function automatic int mg(int k);
        return (k == 3) ? 3 : 4;
    endfunction

    task automatic check(input string tag, input longint obs, input longint expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic model_clear();
        for (int k = 0; k < 4; k++) begin
            macc[k] = 0;
            movf[k] = 1'b0;
        end
    endtask

    task automatic model_accept(input bit last, input int w0, input int w1, input int i0,
                                input int i1, input int a0, input int a1, input int a2,
                                input int a3);
        int     a[4];
        longint dot, sum, lo, hi, span;
        exp_t   ex;
        a  = '{a0, a1, a2, a3};
        ex = '0;
        for (int k = 0; k < 4; k++) begin
            dot = 0;
            if (i0 < mg(k)) dot += longint'(a[i0] * w0);
            if (i1 < mg(k)) dot += longint'(a[i1] * w1);
            sum  = macc[k] + dot;
            span = longint'(1) << aw(k);
            lo   = -(span / 2);
            hi   = (span / 2) - 1;
            if (sum > hi || sum < lo) begin
                movf[k] = 1'b1;
                if (k == 2) begin
                    sum = (sum - lo) % span;
                    if (sum < 0) sum += span;
                    sum += lo;
                end else begin
                    sum = (sum > hi) ? hi : lo;
                end
            end
            macc[k] = sum;
            ex.p[k] = macc[k];
            ex.o[k] = movf[k];
        end
        if (last) begin
            sb.push_back(ex);
            model_clear();
        end
    endtask

    // Presents one packet, waits (bounded) for acceptance, then drops in_valid after the edge.
    task automatic send(input bit last, input int w0, input int w1, input int i0, input int i1,
                        input int a0, input int a1, input int a2, input int a3);
        int waits = 0;
        @(negedge clk);
        in_valid   = 1'b1;
        in_last    = last;
        w_val[0]   = 8'(w0);
        w_val[1]   = 8'(w1);
        w_idx[0]   = 2'(i0);
        w_idx[1]   = 2'(i1);
        act_vec[0] = 8'(a0);
        act_vec[1] = 8'(a1);
        act_vec[2] = 8'(a2);
        act_vec[3] = 8'(a3);
        for (int k = 0; k < 3; k++) act3[k] = act_vec[k];
        #1;
        while (!ir_def && waits < 50) begin
            @(negedge clk);
            #1;
            waits++;
        end
        if (!ir_def) begin
            vectors++;
            miscompares++;
            $error("FAIL send_timeout: observed in_ready %0d expected 1", ir_def);
        end else begin
            model_accept(last, w0, w1, i0, i1, a0, a1, a2, a3);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst      = 1'b1;
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check("rst_out_valid", ov_def, 0);
        check("rst_psum", ps_def, 0);
        check("rst_ovf", of_def, 0);
        @(negedge clk);
        rst = 1'b0;
        model_clear();
        sb.delete();
        @(posedge clk);
        #1;
        check("rst_in_ready", ir_def, 1);
    endtask

    // Result monitor: pops the scoreboard on every output handshake.
    always @(negedge clk) begin
        #1;
        if (!rst && ov_def && out_ready) begin
            if (sb.size() == 0) begin
                check("unexpected_result", ps_def, -1);
            end else begin
                e = sb.pop_front();
                check("psum_def", ps_def, longint'(e.p[0]));
                check("ovf_def", of_def, longint'(e.o[0]));
                check("valid_sat", ov_sat, 1);
                check("psum_sat", ps_sat, longint'(e.p[1]));
                check("ovf_sat", of_sat, longint'(e.o[1]));
                check("valid_wrap", ov_wrap, 1);
                check("psum_wrap", ps_wrap, longint'(e.p[2]));
                check("ovf_wrap", of_wrap, longint'(e.o[2]));
                check("valid_m3", ov_m3, 1);
                check("psum_m3", ps_m3, longint'(e.p[3]));
                check("ovf_m3", of_m3, longint'(e.o[3]));
                $display("result: def=%0d sat=%0d/%0d wrap=%0d/%0d m3=%0d",
                         ps_def, ps_sat, of_sat, ps_wrap, of_wrap, ps_m3);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: observed running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        longint held;
        int     waits;
        model_clear();
        do_reset();

        // Single-packet group: 3*4 + 5*(-1) = 7, valid on the second edge after presentation.
        send(1, 4, -1, 0, 2, 3, -2, 5, 7);
        check("lat_early", ov_def, 0);
        @(posedge clk);
        #1;
        check("lat_valid", ov_def, 1);
        check("lat_psum", ps_def, 7);

        // Three back-to-back +10 packets, then a fresh group of +5.
        send(0, 1, 0, 0, 0, 10, 0, 0, 0);
        send(0, 1, 0, 0, 0, 10, 0, 0, 0);
        send(1, 1, 0, 0, 0, 10, 0, 0, 0);
        send(1, 1, 0, 0, 0, 5, 0, 0, 0);

        // Saturation / wrap at 8 bits: two packets of 127*1.
        send(0, 1, 0, 0, 1, 127, 0, 0, 0);
        send(1, 1, 0, 0, 1, 127, 0, 0, 0);

        // Out-of-range lane on the 3-activation variant.
        send(1, 9, 2, 3, 1, 0, 5, 0, 1);

        // Backpressure: result held five cycles while later packets wait.
        repeat (4) @(negedge clk);
        out_ready = 1'b0;
        fork
            begin
                send(1, 1, 1, 0, 1, 2, 3, 4, 5);
                send(0, 2, 0, 3, 0, 2, 3, 4, 5);
                send(1, 1, 0, 2, 0, 2, 3, 4, 5);
            end
            begin
                waits = 0;
                while (!ov_def && waits < 20) begin
                    @(negedge clk);
                    #1;
                    waits++;
                end
                check("stall_seen", ov_def, 1);
                held = ps_def;
                repeat (5) begin
                    @(negedge clk);
                    #1;
                    check("stall_in_ready", ir_def, 0);
                    check("stall_in_ready_m3", ir_m3, 0);
                    check("stall_in_ready_sat", ir_sat, 0);
                    check("stall_in_ready_wrap", ir_wrap, 0);
                    check("stall_valid", ov_def, 1);
                    check("stall_psum", ps_def, held);
                end
                @(negedge clk);
                out_ready = 1'b1;
            end
        join

        // Reset mid-group drops the partial sum.
        send(0, 1, 0, 0, 0, 50, 0, 0, 0);
        send(0, 1, 0, 0, 0, 50, 0, 0, 0);
        do_reset();
        send(1, 2, 0, 0, 0, 3, 0, 0, 0);

        waits = 0;
        while (sb.size() != 0 && waits < 50) begin
            @(negedge clk);
            waits++;
        end
        @(negedge clk);
        #2;
        check("drain", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
